// File: rtl/nn_act_pipe.sv
// Per-lane activation (STEP/SIGN/RELU/HTANH/LEAKY, LEAKY only with NN_ACT_LEAKY_EN) on LANES custom floats.
// Latency: 2 register stages (input register, result register); 1 beat/cycle sustained.
// Backpressure: valid/ready both sides; in_ready = !s1_valid | !s2_valid | out_ready, outputs hold while stalled.
module nn_act_pipe #(
    parameter int LANES       = 4,
    parameter int E_BIT       = 5,
    parameter int F_BIT       = 10,
    parameter int LEAKY_SHIFT = 3,
    localparam int D_LEN      = E_BIT + F_BIT + 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [2:0]             mode,
    input  logic [D_LEN-1:0]       thresh,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [LANES*D_LEN-1:0] in_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [LANES*D_LEN-1:0] out_data,
    output logic [LANES-1:0]       sat_flag
);

    typedef enum logic [2:0] {
        M_STEP  = 3'd0,
        M_SIGN  = 3'd1,
        M_RELU  = 3'd2,
        M_HTANH = 3'd3,
        M_LEAKY = 3'd4
    } act_mode_e;

    typedef struct packed {
        logic mag_zero;
        logic gt_one;
    } lane_cmp_t;

    localparam logic [D_LEN-1:0] ZERO    = '0;
    localparam logic [D_LEN-1:0] ONE     = {2'b00, {(E_BIT-1){1'b1}}, {F_BIT{1'b0}}};
    localparam logic [D_LEN-2:0] ONE_MAG = ONE[D_LEN-2:0];
    localparam logic [D_LEN-1:0] NEG_ONE = {1'b1, ONE_MAG};

    if (LEAKY_SHIFT < 0 || LEAKY_SHIFT >= (1 << E_BIT)) begin : g_bad_shift
        $error("nn_act_pipe: LEAKY_SHIFT out of exponent range");
    end

    // Sign-magnitude a >= b, with +0 and -0 treated as equal.
    function automatic logic fp_ge(input logic [D_LEN-1:0] a, input logic [D_LEN-1:0] b);
        logic [D_LEN-2:0] ma;
        logic [D_LEN-2:0] mb;
        ma = a[D_LEN-2:0];
        mb = b[D_LEN-2:0];
        if (ma == '0 && mb == '0)
            return 1'b1;
        else if (a[D_LEN-1] != b[D_LEN-1])
            return !a[D_LEN-1];
        else if (!a[D_LEN-1])
            return ma >= mb;
        else
            return ma <= mb;
    endfunction

    logic                   s1_valid;
    logic                   s2_valid;
    logic                   s1_en;
    logic                   s2_en;
    logic [2:0]             s1_mode;
    logic [D_LEN-1:0]       s1_thresh;
    logic [LANES*D_LEN-1:0] s1_data;
    lane_cmp_t [LANES-1:0]  cmp_d;
    lane_cmp_t [LANES-1:0]  s1_cmp;
    logic [LANES*D_LEN-1:0] res_d;
    logic [LANES-1:0]       sat_d;

    assign s2_en     = !s2_valid || out_ready;
    assign s1_en     = !s1_valid || s2_en;
    assign in_ready  = s1_en;
    assign out_valid = s2_valid;

    always_comb begin
        cmp_d = '0;
        for (int k = 0; k < LANES; k++) begin
            cmp_d[k].mag_zero = (in_data[k*D_LEN +: D_LEN-1] == '0);
            cmp_d[k].gt_one   = (in_data[k*D_LEN +: D_LEN-1] > ONE_MAG);
        end
    end

`ifdef NN_ACT_LEAKY_EN
    logic [LANES-1:0] exp_low_d;
    logic [LANES-1:0] s1_exp_low;

    // Exponents at or below the shift would underflow; those lanes flush to zero.
    always_comb begin
        exp_low_d = '0;
        for (int k = 0; k < LANES; k++)
            exp_low_d[k] = (in_data[k*D_LEN+F_BIT +: E_BIT] <= E_BIT'(LEAKY_SHIFT));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            s1_exp_low <= '0;
        else if (s1_en && in_valid)
            s1_exp_low <= exp_low_d;
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid  <= 1'b0;
            s1_mode   <= '0;
            s1_thresh <= '0;
            s1_data   <= '0;
            s1_cmp    <= '0;
        end else if (s1_en) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_mode   <= mode;
                s1_thresh <= thresh;
                s1_data   <= in_data;
                s1_cmp    <= cmp_d;
            end
        end
    end

    always_comb begin
        logic [D_LEN-1:0] x;
        logic [D_LEN-1:0] r;
        res_d = '0;
        sat_d = '0;
        for (int k = 0; k < LANES; k++) begin
            x = s1_data[k*D_LEN +: D_LEN];
            r = x;
            case (s1_mode)
                M_STEP:  r = fp_ge(x, s1_thresh) ? ONE : ZERO;
                M_SIGN:  r = s1_cmp[k].mag_zero ? ZERO : (x[D_LEN-1] ? NEG_ONE : ONE);
                M_RELU:  r = x[D_LEN-1] ? ZERO : x;
                M_HTANH: begin
                    if (s1_cmp[k].gt_one) begin
                        r        = {x[D_LEN-1], ONE_MAG};
                        sat_d[k] = 1'b1;
                    end else if (s1_cmp[k].mag_zero) begin
                        r = ZERO;
                    end
                end
`ifdef NN_ACT_LEAKY_EN
                M_LEAKY: begin
                    if (!x[D_LEN-1])
                        r = x;
                    else if (s1_exp_low[k])
                        r = ZERO;
                    else
                        r = {1'b1, x[D_LEN-2:F_BIT] - E_BIT'(LEAKY_SHIFT), x[F_BIT-1:0]};
                end
`else
                M_LEAKY: r = x[D_LEN-1] ? ZERO : x;
`endif
                default: r = x;
            endcase
            res_d[k*D_LEN +: D_LEN] = r;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid <= 1'b0;
            out_data <= '0;
            sat_flag <= '0;
        end else if (s2_en) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                out_data <= res_d;
                sat_flag <= sat_d;
            end
        end
    end

endmodule

// File: tb/tb_nn_act_pipe.sv
// Directed bench for nn_act_pipe (E_BIT=5, F_BIT=10, LANES=4): per-mode vectors, latency, backpressure, reset.
module tb_nn_act_pipe;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [2:0]  mode;
    logic [15:0] thresh;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_data;
    logic [3:0]  sat_flag;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    nn_act_pipe dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .mode      (mode),
        .thresh    (thresh),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .sat_flag  (sat_flag)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Starts at posedge+1 with an empty pipe; beat sampled on the next edge, result visible after the one after.
    task automatic run_beat(input string tag, input logic [2:0] m, input logic [15:0] th,
                            input logic [63:0] d, input logic [63:0] e, input logic [3:0] es);
        check({tag, "_rdy"}, in_ready, 64'd1);
        mode = m; thresh = th; in_data = d; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0; mode = 3'd7; thresh = 16'h7C00; in_data = '1;
        check({tag, "_lat1"}, out_valid, 64'd0);
        @(posedge clk); #1;
        check({tag, "_vld"}, out_valid, 64'd1);
        check({tag, "_dat"}, out_data, e);
        check({tag, "_sat"}, sat_flag, 64'(es));
        @(posedge clk); #1;
    endtask

    logic [63:0] strm_dat [8];
    logic [63:0] strm_exp [8];
    logic [2:0]  strm_mode [8];
    int          n_acc;
    int          n_out;

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0; mode = '0; thresh = '0; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
        #12;
        check("rst_out_valid", out_valid, 64'd0);
        check("rst_out_data", out_data, 64'd0);
        check("rst_sat", sat_flag, 64'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("rst_in_ready", in_ready, 64'd1);

        run_beat("step", 3'd0, 16'h3800, {16'h0000, 16'hB800, 16'h37FF, 16'h3800},
                 {16'h0000, 16'h0000, 16'h0000, 16'h3C00}, 4'b0000);
        run_beat("step_neg", 3'd0, 16'hB800, {16'hC000, 16'h8000, 16'hB801, 16'hB800},
                 {16'h0000, 16'h3C00, 16'h0000, 16'h3C00}, 4'b0000);
        run_beat("sign", 3'd1, 16'h0000, {16'h0001, 16'h8000, 16'hC000, 16'h4000},
                 {16'h3C00, 16'h0000, 16'hBC00, 16'h3C00}, 4'b0000);
        run_beat("relu", 3'd2, 16'h0000, {16'h0001, 16'h8000, 16'h7BFF, 16'hBC00},
                 {16'h0001, 16'h0000, 16'h7BFF, 16'h0000}, 4'b0000);
        run_beat("htanh", 3'd3, 16'h0000, {16'h3C00, 16'h3800, 16'hC500, 16'h4000},
                 {16'h3C00, 16'h3800, 16'hBC00, 16'h3C00}, 4'b0011);
        run_beat("htanh_neg", 3'd3, 16'h0000, {16'hBC01, 16'hBC00, 16'hB800, 16'h8000},
                 {16'hBC00, 16'hBC00, 16'hB800, 16'h0000}, 4'b1000);
        run_beat("pass6", 3'd6, 16'h0000, {16'hFFFF, 16'h1234, 16'hC500, 16'h8000},
                 {16'hFFFF, 16'h1234, 16'hC500, 16'h8000}, 4'b0000);
`ifdef NN_ACT_LEAKY_EN
        run_beat("leaky", 3'd4, 16'h0000, {16'h0000, 16'h8C00, 16'h4000, 16'hC000},
                 {16'h0000, 16'h0000, 16'h4000, 16'hB400}, 4'b0000);
`else
        run_beat("leaky_relu", 3'd4, 16'h0000, {16'h0000, 16'h8C00, 16'h4000, 16'hC000},
                 {16'h0000, 16'h0000, 16'h4000, 16'h0000}, 4'b0000);
`endif

        // Alternate pass-through and RELU so a mode change mid-stream is exercised too.
        for (int i = 0; i < 8; i++) begin
            logic [15:0] l0;
            l0 = 16'hC000 + 16'(i);
            strm_mode[i] = (i % 2 == 1) ? 3'd2 : 3'd5;
            strm_dat[i]  = {16'h3000 + 16'(i), 16'h2000 + 16'(i), 16'h1000 + 16'(i), l0};
            strm_exp[i]  = {16'h3000 + 16'(i), 16'h2000 + 16'(i), 16'h1000 + 16'(i),
                            (i % 2 == 1) ? 16'h0000 : l0};
        end
        n_acc = 0;
        n_out = 0;
        fork
            begin : producer
                for (int i = 0; i < 8; i++) begin
                    logic acc;
                    int   guard;
                    mode = strm_mode[i]; in_data = strm_dat[i]; in_valid = 1'b1;
                    acc = 1'b0;
                    guard = 0;
                    while (!acc && guard < 50) begin
                        @(negedge clk);
                        acc = in_ready;
                        check("bp_in_ready", in_ready,
                              64'(!((n_acc - n_out) == 2 && !out_ready)));
                        @(posedge clk);
                        if (acc) n_acc++;
                        #1;
                        guard++;
                    end
                    if (!acc) check("bp_accept_timeout", 64'd0, 64'd1);
                end
                in_valid = 1'b0;
            end
            begin : consumer
                logic [3:0]  pat;
                logic [63:0] held;
                logic        stalled;
                logic        fire;
                int          cyc;
                pat = 4'b1001;
                cyc = 0;
                stalled = 1'b0;
                held = '0;
                out_ready = pat[0];
                while (n_out < 8 && cyc < 300) begin
                    @(negedge clk);
                    if (out_valid) begin
                        if (stalled) check("bp_hold", out_data, held);
                        if (out_ready) check("bp_beat", out_data, strm_exp[n_out]);
                        stalled = !out_ready;
                        held = out_data;
                    end else begin
                        stalled = 1'b0;
                    end
                    fire = out_valid && out_ready;
                    @(posedge clk);
                    if (fire) n_out++;
                    #1;
                    cyc++;
                    out_ready = pat[cyc % 4];
                end
                check("bp_count", 64'(n_out), 64'd8);
            end
        join
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("bp_drained", out_valid, 64'd0);

        // Two beats in flight, then an asynchronous reset pulse mid-cycle.
        mode = 3'd5; in_data = 64'h1111_2222_3333_4444; in_valid = 1'b1;
        @(posedge clk); #1;
        in_data = 64'h5555_6666_7777_0888;
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("inflight_vld", out_valid, 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_vld", out_valid, 64'd0);
        check("arst_dat", out_data, 64'd0);
        @(posedge clk); #3;
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("post_rst_idle", out_valid, 64'd0);
        run_beat("post_rst", 3'd1, 16'h0000, {16'h0000, 16'h8001, 16'h0400, 16'hFBFF},
                 {16'h0000, 16'hBC00, 16'h3C00, 16'hBC00}, 4'b0000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
